// File: rtl/mem_slot_scheduler.sv
// Shared RAM/ROM bus slot scheduler: sequences 4-phase windows, alternates VID/CPU slots
// and grants each window to CPU, video, sound or one of two floppy readers.
module mem_slot_scheduler #(
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              _systemReset,
  input  logic              cep,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic              vidReq,
  input  logic [ADDR_W-1:0] vidAddr,
  input  logic              sndReq,
  input  logic [ADDR_W-1:0] sndAddr,
  input  logic              dskReqInt,
  input  logic [ADDR_W-1:0] dskAddrInt,
  input  logic              dskReqExt,
  input  logic [ADDR_W-1:0] dskAddrExt,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memOe,
  output logic              memWe,
  output logic              cpuBusControl,
  output logic              videoBusControl,
  output logic              loadSound,
  output logic              dskReadAckInt,
  output logic              dskReadAckExt,
  output logic [1:0]        phase
);

  typedef enum logic [2:0] {
    OWN_NONE, OWN_CPU, OWN_VID, OWN_SND, OWN_DSKI, OWN_DSKE
  } owner_t;

  owner_t            owner, owner_next;
  logic              slot_cpu, next_slot_cpu;
  logic              wr_latch, snd_pending, snd_req_d, last_ext;
  logic              window_start, snd_edge, grant_snd, rd_ok, wr_ok, strobe_phase;
  logic [1:0]        phase_next;
  logic [ADDR_W-1:0] addr_next;
  owner_t            dsk_owner;

  always_comb begin
    phase_next    = phase + 2'd1;
    window_start  = cep && (phase == 2'd3);
    next_slot_cpu = ~slot_cpu;
    snd_edge      = sndReq & ~snd_req_d;

    // Alternate between the two floppies when both are waiting.
    dsk_owner = OWN_NONE;
    if (dskReqInt && dskReqExt) dsk_owner = last_ext ? OWN_DSKI : OWN_DSKE;
    else if (dskReqInt)         dsk_owner = OWN_DSKI;
    else if (dskReqExt)         dsk_owner = OWN_DSKE;

    owner_next = OWN_NONE;
    if (next_slot_cpu) begin
      if (cpuReq) owner_next = OWN_CPU;
      else        owner_next = dsk_owner;
    end else begin
      if (vidReq)           owner_next = OWN_VID;
      else if (snd_pending) owner_next = OWN_SND;
      else                  owner_next = dsk_owner;
    end

    unique case (owner_next)
      OWN_CPU:  addr_next = cpuAddr;
      OWN_VID:  addr_next = vidAddr;
      OWN_SND:  addr_next = sndAddr;
      OWN_DSKI: addr_next = dskAddrInt;
      OWN_DSKE: addr_next = dskAddrExt;
      default:  addr_next = memAddr;
    endcase

    grant_snd    = window_start && (owner_next == OWN_SND);
    strobe_phase = (phase_next == 2'd1) || (phase_next == 2'd2);
    wr_ok        = (owner == OWN_CPU) && wr_latch;
    rd_ok        = (owner != OWN_NONE) && !wr_ok;
  end

  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      phase           <= 2'd0;
      slot_cpu        <= 1'b0;
      owner           <= OWN_NONE;
      wr_latch        <= 1'b0;
      snd_pending     <= 1'b0;
      snd_req_d       <= 1'b0;
      last_ext        <= 1'b1;
      memAddr         <= '0;
      memOe           <= 1'b0;
      memWe           <= 1'b0;
      cpuBusControl   <= 1'b0;
      videoBusControl <= 1'b0;
      loadSound       <= 1'b0;
      dskReadAckInt   <= 1'b0;
      dskReadAckExt   <= 1'b0;
    end else begin
      snd_req_d     <= sndReq;
      // An edge arriving in the grant clock stays pending for a later window.
      snd_pending   <= (snd_pending && !grant_snd) || snd_edge;
      loadSound     <= 1'b0;
      dskReadAckInt <= 1'b0;
      dskReadAckExt <= 1'b0;
      if (cep) begin
        phase <= phase_next;
        memOe <= strobe_phase && rd_ok;
        memWe <= strobe_phase && wr_ok;
        if (phase == 2'd2) begin
          loadSound     <= (owner == OWN_SND);
          dskReadAckInt <= (owner == OWN_DSKI);
          dskReadAckExt <= (owner == OWN_DSKE);
        end
        if (window_start) begin
          slot_cpu        <= next_slot_cpu;
          owner           <= owner_next;
          memAddr         <= addr_next;
          cpuBusControl   <= (owner_next == OWN_CPU);
          videoBusControl <= (owner_next == OWN_VID);
          if (owner_next == OWN_CPU)  wr_latch <= cpuWe;
          if (owner_next == OWN_DSKI) last_ext <= 1'b0;
          if (owner_next == OWN_DSKE) last_ext <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Bench for mem_slot_scheduler: directed window table, hand sequences for
// mid-window drop and async reset, then random traffic against a window-level model.
module tb_mem_slot_scheduler;

  localparam int AW = 22;
  localparam logic [AW-1:0] A_CPU = 22'h001234, A_VID = 22'h3FA700, A_SND = 22'h3FFD00,
                            A_DI  = 22'h00A000, A_DE  = 22'h00B000;

  logic clk = 1'b0, _systemReset = 1'b0, cep = 1'b0;
  logic cpuReq = 0, cpuWe = 0, vidReq = 0, sndReq = 0, dskReqInt = 0, dskReqExt = 0;
  logic [AW-1:0] cpuAddr = A_CPU, vidAddr = A_VID, sndAddr = A_SND, dskAddrInt = A_DI, dskAddrExt = A_DE;
  logic [AW-1:0] memAddr;
  logic memOe, memWe, cpuBusControl, videoBusControl, loadSound, dskReadAckInt, dskReadAckExt;
  logic [1:0] phase;

  mem_slot_scheduler #(.ADDR_W(AW)) dut (
    .clk(clk), ._systemReset(_systemReset), .cep(cep),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
    .vidReq(vidReq), .vidAddr(vidAddr), .sndReq(sndReq), .sndAddr(sndAddr),
    .dskReqInt(dskReqInt), .dskAddrInt(dskAddrInt), .dskReqExt(dskReqExt), .dskAddrExt(dskAddrExt),
    .memAddr(memAddr), .memOe(memOe), .memWe(memWe),
    .cpuBusControl(cpuBusControl), .videoBusControl(videoBusControl),
    .loadSound(loadSound), .dskReadAckInt(dskReadAckInt), .dskReadAckExt(dskReadAckExt),
    .phase(phase)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Raise cep for one posedge; returns at the following negedge.
  task automatic step_cep();
    cep = 1'b1;
    @(negedge clk);
    cep = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    _systemReset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    _systemReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_reqs(input logic c, input logic w, input logic v, input logic s,
                          input logic di, input logic de);
    cpuReq = c; cpuWe = w; vidReq = v; sndReq = s; dskReqInt = di; dskReqExt = de;
  endtask

  // One row = one window. pulse = {loadSound, ackInt, ackExt}
  typedef struct {
    logic c, w, v, s, di, de;
    logic [AW-1:0] addr;
    logic cbc, vbc, oe, we;
    logic [2:0] pulse;
  } row_t;

  row_t rows[14];

  // ---------- behavioural reference (window-level) ----------
  // owners: 0 none, 1 cpu, 2 vid, 3 snd, 4 disk int, 5 disk ext
  int m_phase, m_win, m_own;
  logic [AW-1:0] m_addr;
  bit m_wr, m_pend, m_sprev, m_last_ext;
  bit e_oe, e_we, e_cbc, e_vbc, e_ls, e_aki, e_ake;

  task automatic model_reset();
    m_phase = 0; m_win = 0; m_own = 0; m_addr = '0; m_wr = 0; m_pend = 0; m_sprev = 0;
    m_last_ext = 1; e_oe = 0; e_we = 0; e_cbc = 0; e_vbc = 0; e_ls = 0; e_aki = 0; e_ake = 0;
  endtask

  function automatic int disk_choice(bit di, bit de, bit last_ext);
    if (di && de) return last_ext ? 4 : 5;
    if (di) return 4;
    if (de) return 5;
    return 0;
  endfunction

  task automatic model_step();
    bit edge_s, gsnd;
    edge_s = sndReq && !m_sprev;
    gsnd = 0;
    e_ls = 0; e_aki = 0; e_ake = 0;
    if (cep) begin
      if (m_phase == 2) begin
        e_ls = (m_own == 3); e_aki = (m_own == 4); e_ake = (m_own == 5);
      end
      m_phase = (m_phase + 1) % 4;
      if (m_phase == 0) begin
        m_win++;
        if (m_win % 2 == 1) m_own = cpuReq ? 1 : disk_choice(dskReqInt, dskReqExt, m_last_ext);
        else if (vidReq) m_own = 2;
        else if (m_pend) m_own = 3;
        else m_own = disk_choice(dskReqInt, dskReqExt, m_last_ext);
        case (m_own)
          1: begin m_addr = cpuAddr; m_wr = cpuWe; end
          2: m_addr = vidAddr;
          3: begin m_addr = sndAddr; gsnd = 1; end
          4: begin m_addr = dskAddrInt; m_last_ext = 0; end
          5: begin m_addr = dskAddrExt; m_last_ext = 1; end
          default: ;
        endcase
        e_cbc = (m_own == 1); e_vbc = (m_own == 2);
      end
      e_oe = (m_phase == 1 || m_phase == 2) && m_own != 0 && !(m_own == 1 && m_wr);
      e_we = (m_phase == 1 || m_phase == 2) && m_own == 1 && m_wr;
    end
    m_pend = (m_pend && !gsnd) || edge_s;
    m_sprev = sndReq;
  endtask

  initial begin
    logic [63:0] exp_v, act_v;

    // Window table starting at the first CPU slot after reset
    rows[0]  = '{1,0,1,0,0,0, A_CPU, 1,0,1,0, 3'b000};
    rows[1]  = '{1,0,1,0,0,0, A_VID, 0,1,1,0, 3'b000};
    rows[2]  = '{1,1,1,0,0,0, A_CPU, 1,0,0,1, 3'b000};
    rows[3]  = '{0,0,0,0,0,0, A_CPU, 0,0,0,0, 3'b000};
    rows[4]  = '{0,0,0,0,1,1, A_DI,  0,0,1,0, 3'b010};
    rows[5]  = '{0,0,0,0,1,1, A_DE,  0,0,1,0, 3'b001};
    rows[6]  = '{0,0,0,1,0,1, A_DE,  0,0,1,0, 3'b001};
    rows[7]  = '{0,0,0,1,1,0, A_SND, 0,0,1,0, 3'b100};
    rows[8]  = '{0,0,0,1,1,0, A_DI,  0,0,1,0, 3'b010};
    rows[9]  = '{0,0,0,1,1,0, A_DI,  0,0,1,0, 3'b010};
    rows[10] = '{0,0,1,0,0,0, A_DI,  0,0,0,0, 3'b000};
    rows[11] = '{0,0,1,1,0,0, A_VID, 0,1,1,0, 3'b000};
    rows[12] = '{1,0,0,1,0,0, A_CPU, 1,0,1,0, 3'b000};
    rows[13] = '{1,0,0,1,0,0, A_SND, 0,0,1,0, 3'b100};

    // Reset state
    #12;
    chk("reset_outputs", {phase, memAddr, memOe, memWe, cpuBusControl, videoBusControl,
                          loadSound, dskReadAckInt, dskReadAckExt}, 64'd0);
    _systemReset = 1'b1;
    @(negedge clk);

    // Idle phase rotation
    for (int i = 0; i < 12; i++) begin
      step_cep();
      chk($sformatf("idle_phase_%0d", i),
          {phase, memOe, memWe, loadSound, dskReadAckInt, dskReadAckExt},
          {2'((i + 1) % 4), 5'b0});
    end

    // Directed windows
    do_reset();
    for (int i = 0; i < 3; i++) step_cep();
    for (int r = 0; r < 14; r++) begin
      set_reqs(rows[r].c, rows[r].w, rows[r].v, rows[r].s, rows[r].di, rows[r].de);
      step_cep();
      chk($sformatf("row%0d_owner", r), {memAddr, cpuBusControl, videoBusControl},
          {rows[r].addr, rows[r].cbc, rows[r].vbc});
      step_cep();
      chk($sformatf("row%0d_strobe", r), {memOe, memWe}, {rows[r].oe, rows[r].we});
      step_cep();
      step_cep();
      chk($sformatf("row%0d_pulse", r), {loadSound, dskReadAckInt, dskReadAckExt}, rows[r].pulse);
    end

    // CPU write, request dropped after the grant (next slot is CPU)
    set_reqs(1, 1, 0, 0, 0, 0);
    step_cep();
    chk("wrdrop_grant", {cpuBusControl, memOe, memWe}, 3'b100);
    cpuReq = 0;
    step_cep();
    chk("wrdrop_ph1", {phase, memOe, memWe}, {2'd1, 2'b01});
    step_cep();
    chk("wrdrop_ph2", {phase, memOe, memWe}, {2'd2, 2'b01});
    step_cep();
    chk("wrdrop_ph3", {phase, memOe, memWe, cpuBusControl}, {2'd3, 3'b001});

    // Async reset during phase 2 of a CPU write
    set_reqs(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step_cep();
    set_reqs(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step_cep();
    chk("arst_pre", {phase, memWe, cpuBusControl}, {2'd2, 2'b11});
    #2 _systemReset = 1'b0;
    #1 chk("arst_immediate", {phase, memWe, memOe, cpuBusControl}, 5'd0);
    @(negedge clk);
    _systemReset = 1'b1;
    set_reqs(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step_cep();
    chk("arst_idle_window", {memAddr, cpuBusControl, videoBusControl}, {22'd0, 2'b00});
    step_cep();
    chk("arst_first_grant", {memAddr, cpuBusControl, memOe}, {A_CPU, 2'b10});

    // Random traffic vs reference model
    set_reqs(0, 0, 0, 0, 0, 0);
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      cep = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) cpuReq = ~cpuReq;
      if ($urandom_range(0, 15) == 0) vidReq = ~vidReq;
      if ($urandom_range(0, 31) == 0) sndReq = ~sndReq;
      if ($urandom_range(0, 15) == 0) dskReqInt = ~dskReqInt;
      if ($urandom_range(0, 15) == 0) dskReqExt = ~dskReqExt;
      cpuWe = $urandom_range(0, 1);
      cpuAddr = AW'($urandom); vidAddr = AW'($urandom); sndAddr = AW'($urandom);
      dskAddrInt = AW'($urandom); dskAddrExt = AW'($urandom);
      model_step();
      @(posedge clk);
      #1;
      exp_v = {2'(m_phase), m_addr, e_oe, e_we, e_cbc, e_vbc, e_ls, e_aki, e_ake};
      act_v = {phase, memAddr, memOe, memWe, cpuBusControl, videoBusControl,
               loadSound, dskReadAckInt, dskReadAckExt};
      chk($sformatf("rand_%0d", n), act_v, exp_v);
      @(negedge clk);
    end
    cep = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
